// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file slave: FSM state
// encoding, command byte field layout and the sample-buffer command address.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_CFG     = 3'd2,
    ST_STATUS  = 3'd3,
    ST_MEMRD   = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  // Command byte: bit 7 selects write, bits 6:0 carry the address.
  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  // Status word shifted out ahead of the sample stream.
  localparam int STATUS_W = 16;

  // Address that selects the status + sample-buffer read.
  localparam logic [CMD_ADDR_W-1:0] MEM_CMD_ADDR = 7'h40;

  // Largest of three widths; sizes the shared MISO shift register.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle strobes for SCK edges and chip-select session boundaries.
// Every output is registered: pin-to-strobe latency is 3 clk.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ncs_spi,
  input  logic sck_spi,
  input  logic mosi_spi,
  output logic sck_rise,
  output logic sck_fall,
  output logic sess_start,
  output logic sess_end,
  output logic mosi_bit
);

  logic sck_meta_r;
  logic sck_sync_r;
  logic sck_prev_r;
  logic ncs_meta_r;
  logic ncs_sync_r;
  logic ncs_prev_r;
  logic mosi_meta_r;
  logic mosi_sync_r;

  // Two-flop synchronisers, edge history and registered edge strobes.
  // The ncs chain resets low so a chip select still held low across reset
  // cannot look like a new falling edge; the session must first end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_prev_r  <= 1'b0;
      ncs_meta_r  <= 1'b0;
      ncs_sync_r  <= 1'b0;
      ncs_prev_r  <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      sess_start  <= 1'b0;
      sess_end    <= 1'b0;
      mosi_bit    <= 1'b0;
    end else begin
      sck_meta_r  <= sck_spi;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      ncs_meta_r  <= ncs_spi;
      ncs_sync_r  <= ncs_meta_r;
      ncs_prev_r  <= ncs_sync_r;
      mosi_meta_r <= mosi_spi;
      mosi_sync_r <= mosi_meta_r;
      sck_rise    <= sck_sync_r & ~sck_prev_r;
      sck_fall    <= ~sck_sync_r & sck_prev_r;
      sess_start  <= ~ncs_sync_r & ncs_prev_r;
      sess_end    <= ncs_sync_r & ~ncs_prev_r;
      mosi_bit    <= mosi_sync_r;
    end
  end

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 slave: a command byte selects either a burst of configuration
// register accesses or a status word followed by a streaming sample-buffer
// read. MISO carries the device ID during the command byte.
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int              NUM_CFG   = 4,
  parameter int              CFG_W     = 32,
  parameter int              MEM_AW    = 12,
  parameter int              MEM_DW    = 16,
  parameter logic [7:0]      DEVICE_ID = 8'h90,
  parameter logic [7:0]      VERSION   = 8'h02,
  parameter logic [CFG_W-1:0] CFG_RESET = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ncs_spi,
  input  logic                     sck_spi,
  input  logic                     mosi_spi,
  output logic                     miso_spi,
  output logic [NUM_CFG*CFG_W-1:0] cfg_out,
  output logic [NUM_CFG-1:0]       cfg_update,
  input  logic [15:0]              status_in,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [MEM_DW-1:0]        mem_data
);

  // One left-aligned shift register serves every field that goes out on MISO.
  localparam int TX_W  = max3(CFG_W, MEM_DW, STATUS_W);
  localparam int CNT_W = $clog2(TX_W);
  localparam logic [7:0] ID_BYTE   = DEVICE_ID | VERSION;
  localparam logic [7:0] NUM_CFG_B = 8'(NUM_CFG);
  localparam logic [TX_W-1:0] ID_WORD = TX_W'(ID_BYTE) << (TX_W - CMD_W);

  logic sck_rise_s;
  logic sck_fall_s;
  logic sess_start_s;
  logic sess_end_s;
  logic mosi_bit_s;

  state_t state_r;
  state_t state_nxt_s;

  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_last_s;
  logic                     counting_s;
  logic                     word_done_s;
  logic [CFG_W-1:0]         rx_r;
  logic [CFG_W-1:0]         rx_word_s;
  logic [CMD_W-1:0]         cmd_byte_s;
  logic [CMD_ADDR_W-1:0]    cmd_addr_s;
  logic                     cmd_is_cfg_s;
  logic                     wr_r;
  logic [7:0]               idx_r;
  logic [NUM_CFG*CFG_W-1:0] cfg_r;
  logic [NUM_CFG-1:0]       cfg_upd_r;
  logic [CFG_W-1:0]         cfg_rd_s;
  logic [STATUS_W-1:0]      status_r;
  logic [TX_W-1:0]          tx_r;
  logic [TX_W-1:0]          load_word_s;
  logic                     miso_r;
  logic [MEM_AW-1:0]        mem_addr_r;

  spi_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ncs_spi    (ncs_spi),
    .sck_spi    (sck_spi),
    .mosi_spi   (mosi_spi),
    .sck_rise   (sck_rise_s),
    .sck_fall   (sck_fall_s),
    .sess_start (sess_start_s),
    .sess_end   (sess_end_s),
    .mosi_bit   (mosi_bit_s)
  );

  // Field length per state and the word-complete strobe on the final rising edge.
  always_comb begin
    cnt_last_s = '0;
    counting_s = 1'b0;
    case (state_r)
      ST_CMD: begin
        cnt_last_s = CNT_W'(CMD_W - 1);
        counting_s = 1'b1;
      end
      ST_CFG: begin
        cnt_last_s = CNT_W'(CFG_W - 1);
        counting_s = 1'b1;
      end
      ST_STATUS: begin
        cnt_last_s = CNT_W'(STATUS_W - 1);
        counting_s = 1'b1;
      end
      ST_MEMRD: begin
        cnt_last_s = CNT_W'(MEM_DW - 1);
        counting_s = 1'b1;
      end
      default: begin
        cnt_last_s = '0;
        counting_s = 1'b0;
      end
    endcase
    word_done_s  = sck_rise_s & counting_s & (cnt_r == cnt_last_s);
    rx_word_s    = {rx_r[CFG_W-2:0], mosi_bit_s};
    cmd_byte_s   = rx_word_s[CMD_W-1:0];
    cmd_addr_s   = cmd_byte_s[CMD_ADDR_W-1:0];
    cmd_is_cfg_s = ({1'b0, cmd_addr_s} < NUM_CFG_B);
  end

  // Read mux for the register under the burst index; out-of-range reads as zero.
  always_comb begin
    cfg_rd_s = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      cfg_rd_s = cfg_rd_s | ({CFG_W{idx_r == 8'(k)}} & cfg_r[k*CFG_W +: CFG_W]);
    end
  end

  // Left-aligned word to present on MISO when a new field begins.
  always_comb begin
    load_word_s = '0;
    case (state_r)
      ST_CFG:    load_word_s = TX_W'(cfg_rd_s) << (TX_W - CFG_W);
      ST_STATUS: load_word_s = TX_W'(status_r) << (TX_W - STATUS_W);
      ST_MEMRD:  load_word_s = TX_W'(mem_data) << (TX_W - MEM_DW);
      default:   load_word_s = '0;
    endcase
  end

  // Next-state logic; session end overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (sess_end_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sess_start_s) state_nxt_s = ST_CMD;
          else              state_nxt_s = ST_IDLE;
        end
        ST_CMD: begin
          if (word_done_s) begin
            if (cmd_is_cfg_s)                     state_nxt_s = ST_CFG;
            else if (cmd_addr_s == MEM_CMD_ADDR)  state_nxt_s = ST_STATUS;
            else                                  state_nxt_s = ST_DISCARD;
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_STATUS: begin
          if (word_done_s) state_nxt_s = ST_MEMRD;
          else             state_nxt_s = ST_STATUS;
        end
        ST_CFG:     state_nxt_s = ST_CFG;
        ST_MEMRD:   state_nxt_s = ST_MEMRD;
        ST_DISCARD: state_nxt_s = ST_DISCARD;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Bit counter, receive shifter, command latch, burst index and sample address.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= '0;
      rx_r       <= '0;
      wr_r       <= 1'b0;
      idx_r      <= 8'd0;
      status_r   <= '0;
      mem_addr_r <= '0;
    end else begin
      if (sess_start_s || sess_end_s || word_done_s) begin
        cnt_r <= '0;
      end else if (sck_rise_s && counting_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (sck_rise_s) begin
        rx_r <= rx_word_s;
      end
      if (word_done_s && state_r == ST_CMD) begin
        wr_r     <= cmd_byte_s[CMD_WR_BIT];
        idx_r    <= {1'b0, cmd_addr_s};
        status_r <= status_in;
        if (cmd_addr_s == MEM_CMD_ADDR) begin
          mem_addr_r <= '0;
        end
      end else if (word_done_s && state_r == ST_CFG && idx_r < NUM_CFG_B) begin
        idx_r <= idx_r + 8'd1;
      end else if (sck_fall_s && state_r == ST_MEMRD && cnt_r == '0) begin
        mem_addr_r <= mem_addr_r + MEM_AW'(1);
      end
    end
  end

  // MISO shifter: ID at session start, new field loaded on its first falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r   <= '0;
      miso_r <= 1'b0;
    end else if (sess_start_s) begin
      miso_r <= ID_BYTE[7];
      tx_r   <= {ID_WORD[TX_W-2:0], 1'b0};
    end else if (sess_end_s || state_r == ST_IDLE || state_r == ST_DISCARD) begin
      miso_r <= 1'b0;
      tx_r   <= '0;
    end else if (sck_fall_s && cnt_r == '0 && state_r != ST_CMD) begin
      miso_r <= load_word_s[TX_W-1];
      tx_r   <= {load_word_s[TX_W-2:0], 1'b0};
    end else if (sck_fall_s) begin
      miso_r <= tx_r[TX_W-1];
      tx_r   <= {tx_r[TX_W-2:0], 1'b0};
    end
  end

  // Config registers and per-register update strobes; only whole words commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_r     <= {NUM_CFG{CFG_RESET}};
      cfg_upd_r <= '0;
    end else begin
      cfg_upd_r <= '0;
      if (word_done_s && state_r == ST_CFG && wr_r) begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (idx_r == 8'(k)) begin
            cfg_r[k*CFG_W +: CFG_W] <= rx_word_s;
            cfg_upd_r[k]            <= 1'b1;
          end
        end
      end
    end
  end

  assign miso_spi   = miso_r;
  assign cfg_out    = cfg_r;
  assign cfg_update = cfg_upd_r;
  assign mem_addr   = mem_addr_r;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench for spi_regfile_slave: an SPI master driven from one
// initial block, a one-cycle-latency sample memory and an update-strobe
// monitor. A 4-bit sample address keeps the wrap-around session short.
module tb_spi_regfile_slave;

  localparam int NUM_CFG = 4;
  localparam int CFG_W   = 32;
  localparam int MEM_AW  = 4;
  localparam int MEM_DW  = 16;
  localparam int HALF    = 60;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     ncs_spi = 1'b1;
  logic                     sck_spi = 1'b0;
  logic                     mosi_spi = 1'b0;
  logic                     miso_spi;
  logic [NUM_CFG*CFG_W-1:0] cfg_out;
  logic [NUM_CFG-1:0]       cfg_update;
  logic [15:0]              status_in = 16'h0000;
  logic [MEM_AW-1:0]        mem_addr;
  logic [MEM_DW-1:0]        mem_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  int         upd_cyc = 0;
  int         upd_bit [NUM_CFG];
  logic [3:0] upd_last = 4'b0000;

  always #5 clk = ~clk;

  spi_regfile_slave #(
    .NUM_CFG (NUM_CFG),
    .CFG_W   (CFG_W),
    .MEM_AW  (MEM_AW),
    .MEM_DW  (MEM_DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ncs_spi    (ncs_spi),
    .sck_spi    (sck_spi),
    .mosi_spi   (mosi_spi),
    .miso_spi   (miso_spi),
    .cfg_out    (cfg_out),
    .cfg_update (cfg_update),
    .status_in  (status_in),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  function automatic logic [15:0] mem_fn(input logic [3:0] a);
    return {a, ~a, a, ~a};
  endfunction

  // Sample memory with one clock of read latency.
  always @(posedge clk) mem_data <= mem_fn(mem_addr);

  // Count update-strobe cycles per bit and remember the last non-zero pattern.
  always @(posedge clk) begin
    if (cfg_update != 4'b0000) begin
      upd_cyc  <= upd_cyc + 1;
      upd_last <= cfg_update;
      for (int k = 0; k < NUM_CFG; k++) begin
        if (cfg_update[k]) upd_bit[k] <= upd_bit[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi_spi = b;
    #HALF;
    r = miso_spi;
    sck_spi = 1'b1;
    #HALF;
    sck_spi = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] v, input int n, output logic [31:0] r);
    logic b;
    r = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], b);
      r = {r[30:0], b};
    end
  endtask

  task automatic cs_low();
    ncs_spi = 1'b0;
  endtask

  task automatic cs_high();
    #HALF;
    ncs_spi  = 1'b1;
    mosi_spi = 1'b0;
    #(4*HALF);
  endtask

  initial begin
    logic [31:0] r;
    int          c0;
    int          b0 [NUM_CFG];

    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #20;

    // Reset state
    check("rst_cfg_lo", cfg_out[63:0], 64'h0);
    check("rst_cfg_hi", cfg_out[127:64], 64'h0);
    check("rst_update", cfg_update, 4'b0000);
    check("rst_miso", miso_spi, 1'b0);
    check("rst_mem_addr", mem_addr, 4'h0);

    // Read ID
    c0 = upd_cyc;
    cs_low();
    spi_word(32'h00, 8, r);
    cs_high();
    check("id_byte", r[7:0], 8'h92);
    check("id_no_update", upd_cyc - c0, 0);

    // Single write to reg1
    c0 = upd_cyc;
    b0 = upd_bit;
    cs_low();
    spi_word(32'h81, 8, r);
    check("wr1_id", r[7:0], 8'h92);
    spi_word(32'hDEADBEEF, 32, r);
    check("wr1_old_value", r, 32'h0);
    cs_high();
    check("wr1_reg1", cfg_out[63:32], 32'hDEADBEEF);
    check("wr1_reg0", cfg_out[31:0], 32'h0);
    check("wr1_reg32", cfg_out[127:64], 64'h0);
    check("wr1_upd_cycles", upd_cyc - c0, 1);
    check("wr1_upd_bit1", upd_bit[1] - b0[1], 1);
    check("wr1_upd_pattern", upd_last, 4'b0010);

    // Readback of reg1
    c0 = upd_cyc;
    cs_low();
    spi_word(32'h01, 8, r);
    spi_word(32'h0, 32, r);
    cs_high();
    check("rd1_value", r, 32'hDEADBEEF);
    check("rd1_no_update", upd_cyc - c0, 0);

    // Burst write from reg2: third word falls off the end
    c0 = upd_cyc;
    b0 = upd_bit;
    cs_low();
    spi_word(32'h82, 8, r);
    spi_word(32'h11223344, 32, r);
    check("bw_old2", r, 32'h0);
    spi_word(32'hA5A55A5A, 32, r);
    check("bw_old3", r, 32'h0);
    spi_word(32'hCAFEF00D, 32, r);
    check("bw_past_end", r, 32'h0);
    cs_high();
    check("bw_reg2", cfg_out[95:64], 32'h11223344);
    check("bw_reg3", cfg_out[127:96], 32'hA5A55A5A);
    check("bw_reg1", cfg_out[63:32], 32'hDEADBEEF);
    check("bw_reg0", cfg_out[31:0], 32'h0);
    check("bw_upd_cycles", upd_cyc - c0, 2);
    check("bw_upd_bit2", upd_bit[2] - b0[2], 1);
    check("bw_upd_bit3", upd_bit[3] - b0[3], 1);

    // Burst read from reg2
    cs_low();
    spi_word(32'h02, 8, r);
    spi_word(32'h0, 32, r);
    check("br_reg2", r, 32'h11223344);
    spi_word(32'h0, 32, r);
    check("br_reg3", r, 32'hA5A55A5A);
    spi_word(32'h0, 32, r);
    check("br_past_end", r, 32'h0);
    cs_high();

    // Partial word to reg0
    c0 = upd_cyc;
    cs_low();
    spi_word(32'h80, 8, r);
    spi_word(32'hFFFFF, 20, r);
    cs_high();
    check("partial_reg0", cfg_out[31:0], 32'h0);
    check("partial_no_update", upd_cyc - c0, 0);

    // Unmapped address: discarded
    c0 = upd_cyc;
    cs_low();
    spi_word(32'h85, 8, r);
    spi_word(32'hFFFFFFFF, 32, r);
    check("discard_miso", r, 32'h0);
    cs_high();
    check("discard_no_update", upd_cyc - c0, 0);
    check("discard_reg1", cfg_out[63:32], 32'hDEADBEEF);

    // Status then streaming sample read with address wrap
    status_in = 16'h1234;
    cs_low();
    spi_word(32'h40, 8, r);
    check("mem_id", r[7:0], 8'h92);
    status_in = 16'hFFFF;
    spi_word(32'h0, 16, r);
    check("mem_status", r[15:0], 16'h1234);
    for (int k = 0; k < 17; k++) begin
      spi_word(32'hFFFF, 16, r);
      check($sformatf("mem_word_%0d", k), r[15:0], mem_fn(4'(k)));
    end
    cs_high();
    check("mem_addr_end", mem_addr, 4'h2);

    // Reset in the middle of a burst write
    c0 = upd_cyc;
    cs_low();
    spi_word(32'h80, 8, r);
    spi_word(32'h01020304, 32, r);
    check("rstmid_reg0_pre", cfg_out[31:0], 32'h01020304);
    spi_word(32'hAA, 8, r);
    rst = 1'b1;
    #20;
    rst = 1'b0;
    spi_word(32'h55555555, 32, r);
    check("rstmid_miso_idle", r, 32'h0);
    spi_word(32'hFFFFFFFF, 32, r);
    cs_high();
    check("rstmid_cfg_lo", cfg_out[63:0], 64'h0);
    check("rstmid_cfg_hi", cfg_out[127:64], 64'h0);
    check("rstmid_upd_cycles", upd_cyc - c0, 1);
    check("rstmid_miso", miso_spi, 1'b0);

    // Normal decoding after the reset
    cs_low();
    spi_word(32'h83, 8, r);
    check("post_id", r[7:0], 8'h92);
    spi_word(32'h0BADF00D, 32, r);
    cs_high();
    cs_low();
    spi_word(32'h03, 8, r);
    spi_word(32'h0, 32, r);
    cs_high();
    check("post_reg3", r, 32'h0BADF00D);
    check("post_cfg_out3", cfg_out[127:96], 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
